// File: rtl/mirfak_muldiv_ctrl.sv
// EX-stage sequencer for the M-extension multiplier/divider units.
// Special-case operands are resolved locally; everything else is dispatched to a unit.
module mirfak_muldiv_ctrl (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_valid_i,
  input  logic [2:0]  req_funct3_i,
  input  logic [31:0] req_op_a_i,
  input  logic [31:0] req_op_b_i,
  input  logic        hold_i,
  input  logic        abort_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] result_o,
  output logic        mult_enable_o,
  output logic [1:0]  mult_cmd_o,
  output logic        mult_abort_o,
  input  logic        mult_ack_i,
  input  logic [31:0] mult_result_i,
  output logic        div_enable_o,
  output logic [1:0]  div_cmd_o,
  output logic        div_abort_o,
  input  logic        div_ack_i,
  input  logic [31:0] div_result_i,
  output logic [31:0] unit_op_a_o,
  output logic [31:0] unit_op_b_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t      state;
  logic [31:0] op_a_q;
  logic [31:0] op_b_q;
  logic [31:0] result_q;
  logic [1:0]  cmd_q;

  logic        a_zero;
  logic        b_zero;
  logic        div_overflow;
  logic        fast_hit;
  logic [31:0] fast_result;

  assign a_zero       = (req_op_a_i == 32'd0);
  assign b_zero       = (req_op_b_i == 32'd0);
  assign div_overflow = (req_op_a_i == 32'h8000_0000) && (req_op_b_i == 32'hFFFF_FFFF);

  // funct3[1] separates REM from DIV, funct3[0] marks the unsigned variants.
  always_comb begin
    fast_hit    = 1'b0;
    fast_result = 32'd0;
    if (!req_funct3_i[2]) begin
      if (a_zero || b_zero) begin
        fast_hit    = 1'b1;
        fast_result = 32'd0;
      end
    end else if (b_zero) begin
      fast_hit    = 1'b1;
      fast_result = req_funct3_i[1] ? req_op_a_i : 32'hFFFF_FFFF;
    end else if (div_overflow && !req_funct3_i[0]) begin
      fast_hit    = 1'b1;
      fast_result = req_funct3_i[1] ? 32'd0 : 32'h8000_0000;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state    <= S_IDLE;
      op_a_q   <= 32'd0;
      op_b_q   <= 32'd0;
      result_q <= 32'd0;
      cmd_q    <= 2'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid_i && !abort_i) begin
            op_a_q <= req_op_a_i;
            op_b_q <= req_op_b_i;
            cmd_q  <= req_funct3_i[1:0];
            if (fast_hit) begin
              result_q <= fast_result;
              state    <= S_DONE;
            end else begin
              state <= req_funct3_i[2] ? S_DIV : S_MUL;
            end
          end
        end
        S_MUL: begin
          if (abort_i) begin
            state <= S_IDLE;
          end else if (mult_ack_i) begin
            result_q <= mult_result_i;
            state    <= S_DONE;
          end
        end
        S_DIV: begin
          if (abort_i) begin
            state <= S_IDLE;
          end else if (div_ack_i) begin
            result_q <= div_result_i;
            state    <= S_DONE;
          end
        end
        S_DONE: begin
          if (abort_i || !hold_i) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Enables and done come straight from the state register so the units see clean levels.
  assign mult_enable_o = (state == S_MUL);
  assign div_enable_o  = (state == S_DIV);
  assign done_o        = (state == S_DONE);
  assign busy_o        = req_valid_i && (state != S_DONE);
  assign mult_abort_o  = abort_i && (state == S_MUL);
  assign div_abort_o   = abort_i && (state == S_DIV);
  assign result_o      = result_q;
  assign mult_cmd_o    = cmd_q;
  assign div_cmd_o     = cmd_q;
  assign unit_op_a_o   = op_a_q;
  assign unit_op_b_o   = op_b_q;

endmodule

// File: tb/tb_mirfak_muldiv_ctrl.sv
// Randomized self-checking bench for mirfak_muldiv_ctrl; the units are mocked with
// arithmetic RISC-V M-extension results and programmable ack latency.
module tb_mirfak_muldiv_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        req_valid;
  logic [2:0]  req_funct3;
  logic [31:0] req_op_a;
  logic [31:0] req_op_b;
  logic        hold;
  logic        abort;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        mult_en;
  logic [1:0]  mult_cmd;
  logic        mult_abort;
  logic        mult_ack;
  logic [31:0] mult_res;
  logic        div_en;
  logic [1:0]  div_cmd;
  logic        div_abort;
  logic        div_ack;
  logic [31:0] div_res;
  logic [31:0] unit_op_a;
  logic [31:0] unit_op_b;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  mirfak_muldiv_ctrl dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .req_valid_i   (req_valid),
    .req_funct3_i  (req_funct3),
    .req_op_a_i    (req_op_a),
    .req_op_b_i    (req_op_b),
    .hold_i        (hold),
    .abort_i       (abort),
    .busy_o        (busy),
    .done_o        (done),
    .result_o      (result),
    .mult_enable_o (mult_en),
    .mult_cmd_o    (mult_cmd),
    .mult_abort_o  (mult_abort),
    .mult_ack_i    (mult_ack),
    .mult_result_i (mult_res),
    .div_enable_o  (div_en),
    .div_cmd_o     (div_cmd),
    .div_abort_o   (div_abort),
    .div_ack_i     (div_ack),
    .div_result_i  (div_res),
    .unit_op_a_o   (unit_op_a),
    .unit_op_b_o   (unit_op_b)
  );

  // Architectural M-extension result, computed with 64-bit arithmetic.
  function automatic logic [31:0] ref_result(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] b);
    longint          sa, sb, ps;
    longint unsigned ua, ub, pu;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    ref_result = 32'd0;
    case (f3)
      3'd0: begin pu = ua * ub; ref_result = pu[31:0]; end
      3'd1: begin ps = sa * sb; ref_result = ps[63:32]; end
      3'd2: begin ps = sa * longint'(ub); ref_result = ps[63:32]; end
      3'd3: begin pu = ua * ub; ref_result = pu[63:32]; end
      3'd4: if (b == 32'd0) ref_result = 32'hFFFF_FFFF;
            else begin ps = sa / sb; ref_result = ps[31:0]; end
      3'd5: if (b == 32'd0) ref_result = 32'hFFFF_FFFF;
            else ref_result = a / b;
      3'd6: if (b == 32'd0) ref_result = a;
            else begin ps = sa % sb; ref_result = ps[31:0]; end
      default: if (b == 32'd0) ref_result = a;
               else ref_result = a % b;
    endcase
  endfunction

  function automatic bit ref_special(input logic [2:0] f3, input logic [31:0] a,
                                     input logic [31:0] b);
    if (!f3[2]) return (a == 32'd0) || (b == 32'd0);
    return (b == 32'd0) ||
           (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return $urandom_range(1, 200);
      default: return $urandom;
    endcase
  endfunction

  // One full operation: request, optional unit phase with ack after lat cycles, DONE held hold_n extra cycles.
  task automatic do_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input int lat, input int hold_n, input string tag);
    logic [31:0] exp;
    bit          fast;
    exp  = ref_result(f3, a, b);
    fast = ref_special(f3, a, b);
    @(negedge clk_i);
    checks++;
    if (done !== 1'b0) begin
      errors++; $display("[TB] FAIL %s idle_done got %b want 0", tag, done);
    end
    req_valid = 1'b1; req_funct3 = f3; req_op_a = a; req_op_b = b;
    hold = 1'b0; abort = 1'b0;
    mult_ack = 1'b0; div_ack = 1'b0;
    mult_res = $urandom; div_res = $urandom;
    #1;
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("[TB] FAIL %s req_busy got %b want 1", tag, busy);
    end
    if (!fast) begin
      for (int k = 1; k <= lat; k++) begin
        @(negedge clk_i);
        checks++;
        if ({mult_en, div_en} !== (f3[2] ? 2'b01 : 2'b10)) begin
          errors++; $display("[TB] FAIL %s enables got %b want %b", tag, {mult_en, div_en},
                             (f3[2] ? 2'b01 : 2'b10));
        end
        checks++;
        if ({done, busy} !== 2'b01) begin
          errors++; $display("[TB] FAIL %s unit_done_busy got %b want 01", tag, {done, busy});
        end
        checks++;
        if ({mult_cmd, div_cmd, unit_op_a, unit_op_b} !== {f3[1:0], f3[1:0], a, b}) begin
          errors++; $display("[TB] FAIL %s latched got %h/%h/%h want %h/%h/%h", tag,
                             mult_cmd, unit_op_a, unit_op_b, f3[1:0], a, b);
        end
        req_op_a = $urandom; req_op_b = $urandom;
        if (k == lat) begin
          if (f3[2]) begin div_ack = 1'b1; div_res = exp; end
          else begin mult_ack = 1'b1; mult_res = exp; end
        end else begin
          mult_res = $urandom; div_res = $urandom;
        end
      end
    end
    @(negedge clk_i);
    mult_ack = 1'b0; div_ack = 1'b0;
    mult_res = $urandom; div_res = $urandom;
    checks++;
    if ({done, busy, mult_en, div_en} !== 4'b1000) begin
      errors++; $display("[TB] FAIL %s done_flags got %b want 1000", tag,
                         {done, busy, mult_en, div_en});
    end
    checks++;
    if (result !== exp) begin
      errors++; $display("[TB] FAIL %s result got %h want %h", tag, result, exp);
    end
    for (int h = 0; h < hold_n; h++) begin
      hold = 1'b1;
      @(negedge clk_i);
      checks++;
      if (done !== 1'b1 || result !== exp) begin
        errors++; $display("[TB] FAIL %s hold got done=%b res=%h want 1/%h", tag, done, result, exp);
      end
    end
    hold = 1'b0;
  endtask

  task automatic go_idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk_i);
      req_valid = 1'b0; hold = 1'b0; abort = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_ni = 1'b0; req_valid = 1'b0; req_funct3 = 3'd0; req_op_a = 32'd0; req_op_b = 32'd0;
    hold = 1'b0; abort = 1'b0; mult_ack = 1'b0; div_ack = 1'b0;
    mult_res = 32'd0; div_res = 32'd0;
    @(posedge clk_i); #1;
    checks++;
    if ({busy, done, mult_en, div_en, mult_abort, div_abort} !== 6'd0) begin
      errors++; $display("[TB] FAIL reset_flags got %b want 000000",
                         {busy, done, mult_en, div_en, mult_abort, div_abort});
    end
    checks++;
    if ({result, unit_op_a, unit_op_b, mult_cmd, div_cmd} !== 100'd0) begin
      errors++; $display("[TB] FAIL reset_data got %h/%h/%h want 0", result, unit_op_a, unit_op_b);
    end
    @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  task automatic test_directed();
    do_op(3'd0, 32'd7, 32'd6, 3, 0, "mul_7x6");
    do_op(3'd5, 32'd100, 32'd0, 0, 0, "divu_by_zero");
    do_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, "rem_overflow");
    do_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, "div_overflow");
    do_op(3'd7, 32'd5, 32'd0, 0, 0, "remu_by_zero");
    go_idle(1);
  endtask

  task automatic test_back_to_back();
    do_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2, 3, "mulhu_hold");
    do_op(3'd0, 32'd12, 32'd11, 1, 0, "mul_b2b");
    go_idle(2);
  endtask

  task automatic test_abort_div();
    @(negedge clk_i);
    req_valid = 1'b1; req_funct3 = 3'd4; req_op_a = 32'd100; req_op_b = 32'd7;
    @(negedge clk_i);
    checks++;
    if (div_en !== 1'b1) begin
      errors++; $display("[TB] FAIL abort_div_en got %b want 1", div_en);
    end
    @(negedge clk_i);
    abort = 1'b1;
    #1;
    checks++;
    if ({div_abort, mult_abort} !== 2'b10) begin
      errors++; $display("[TB] FAIL abort_pulse got %b want 10", {div_abort, mult_abort});
    end
    @(negedge clk_i);
    abort = 1'b0; req_valid = 1'b0;
    checks++;
    if ({done, div_en, div_abort} !== 3'b000) begin
      errors++; $display("[TB] FAIL abort_idle got %b want 000", {done, div_en, div_abort});
    end
    div_ack = 1'b1; div_res = 32'd14;
    @(negedge clk_i);
    div_ack = 1'b0;
    checks++;
    if ({done, div_en} !== 2'b00) begin
      errors++; $display("[TB] FAIL stray_ack got %b want 00", {done, div_en});
    end
    go_idle(1);
  endtask

  task automatic test_abort_with_ack();
    @(negedge clk_i);
    req_valid = 1'b1; req_funct3 = 3'd5; req_op_a = 32'd90; req_op_b = 32'd9;
    @(negedge clk_i);
    abort = 1'b1; div_ack = 1'b1; div_res = 32'd10;
    @(negedge clk_i);
    abort = 1'b0; div_ack = 1'b0; req_valid = 1'b0;
    checks++;
    if ({done, div_en} !== 2'b00) begin
      errors++; $display("[TB] FAIL abort_ack got %b want 00", {done, div_en});
    end
    @(negedge clk_i);
    checks++;
    if (done !== 1'b0) begin
      errors++; $display("[TB] FAIL abort_ack_late got %b want 0", done);
    end
  endtask

  task automatic test_abort_done();
    @(negedge clk_i);
    req_valid = 1'b1; req_funct3 = 3'd1; req_op_a = 32'd0; req_op_b = 32'd3;
    @(negedge clk_i);
    req_valid = 1'b0;
    checks++;
    if (done !== 1'b1) begin
      errors++; $display("[TB] FAIL abort_done_pre got %b want 1", done);
    end
    hold = 1'b1; abort = 1'b1;
    @(negedge clk_i);
    hold = 1'b0; abort = 1'b0;
    checks++;
    if (done !== 1'b0) begin
      errors++; $display("[TB] FAIL abort_done got %b want 0", done);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk_i);
    req_valid = 1'b1; req_funct3 = 3'd1; req_op_a = 32'h1234; req_op_b = 32'h55;
    @(negedge clk_i);
    checks++;
    if ({mult_en, mult_cmd} !== 3'b101) begin
      errors++; $display("[TB] FAIL mid_pre got %b want 101", {mult_en, mult_cmd});
    end
    rst_ni = 1'b0;
    #1;
    checks++;
    if ({mult_en, div_en, done, mult_cmd, unit_op_a, result} !== 69'd0) begin
      errors++; $display("[TB] FAIL mid_reset got en=%b done=%b cmd=%h a=%h res=%h want 0",
                         mult_en, done, mult_cmd, unit_op_a, result);
    end
    @(negedge clk_i);
    req_valid = 1'b0;
    rst_ni = 1'b1;
    @(negedge clk_i);
  endtask

  task automatic test_random();
    logic [2:0] f3;
    for (int i = 0; i < 30; i++) begin
      f3 = 3'($urandom_range(0, 7));
      do_op(f3, pick_operand(), pick_operand(), $urandom_range(1, 4), $urandom_range(0, 2),
            $sformatf("rand%0d_f%0d", i, f3));
      if ($urandom_range(0, 2) == 0) go_idle(1);
    end
    go_idle(1);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_abort_div();
    test_abort_with_ack();
    test_abort_done();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
